// File: rtl/fir_pkg.sv
// fir_pkg: width helpers shared by the FIR multiply-accumulate datapath
package fir_pkg;

    function automatic int prod_bits(input int in_bits, input int coef_bits);
        return in_bits + coef_bits;
    endfunction

    function automatic int acc_bits(input int in_bits, input int coef_bits, input int taps);
        return in_bits + coef_bits + $clog2(taps) + 1;
    endfunction

    function automatic int counter_bits(input int taps);
        return taps > 1 ? $clog2(taps) : 1;
    endfunction

endpackage

// File: rtl/fir_round_sat.sv
// fir_round_sat: round-half-up arithmetic right shift followed by saturation to OUT_BITS
module fir_round_sat #(
    parameter int IN_BITS  = 38,
    parameter int OUT_BITS = 16,
    parameter int SHIFT    = 15
) (
    input  logic signed [IN_BITS-1:0]  din,
    output logic signed [OUT_BITS-1:0] dout,
    output logic                       sat
);

    localparam int W = IN_BITS + 1;
    localparam logic signed [W-1:0] HALF = W'(1) << (SHIFT - 1);
    localparam logic signed [W-1:0] MAXV = {{(W - OUT_BITS + 1){1'b0}}, {(OUT_BITS - 1){1'b1}}};
    localparam logic signed [W-1:0] MINV = {{(W - OUT_BITS + 1){1'b1}}, {(OUT_BITS - 1){1'b0}}};

    logic signed [W-1:0] biased;
    logic signed [W-1:0] shifted;
    logic                hi;
    logic                lo;

    assign biased  = {din[IN_BITS-1], din} + HALF;
    assign shifted = biased >>> SHIFT;
    assign hi      = shifted > MAXV;
    assign lo      = shifted < MINV;
    assign sat     = hi | lo;
    assign dout    = hi ? MAXV[OUT_BITS-1:0] : lo ? MINV[OUT_BITS-1:0] : shifted[OUT_BITS-1:0];

endmodule

// File: rtl/fir_mac_accumulator.sv
// fir_mac_accumulator: serial MAC summing one product per cycle, emitting one rounded, saturated sample per round
module fir_mac_accumulator
    import fir_pkg::*;
#(
    parameter int  FILTER_IN_BITS  = 16,
    parameter int  COEFF_BITS      = 16,
    parameter int  FILTER_OUT_BITS = 16,
    parameter int  NUMBER_OF_TAPS  = 64,
    parameter int  OUT_SHIFT       = 15,
    localparam int COUNTER_BITS    = counter_bits(NUMBER_OF_TAPS)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              phase_min,
    input  logic        [COUNTER_BITS-1:0]    current_count,
    input  logic signed [FILTER_IN_BITS-1:0]  delay_filter_in,
    input  logic signed [COEFF_BITS-1:0]      coeff,
    input  logic                              clear_sat,
    output logic signed [FILTER_OUT_BITS-1:0] filter_out,
    output logic                              filter_out_valid,
    output logic                              sat_flag
);

    localparam int PROD_BITS = prod_bits(FILTER_IN_BITS, COEFF_BITS);
    localparam int ACC_BITS  = acc_bits(FILTER_IN_BITS, COEFF_BITS, NUMBER_OF_TAPS);

    logic signed [PROD_BITS-1:0]       prod_r;
    logic                              first_r;
    logic                              last_r;
    logic                              armed;
    logic signed [ACC_BITS-1:0]        acc;
    logic signed [ACC_BITS-1:0]        sum;
    logic                              emit;
    logic signed [FILTER_OUT_BITS-1:0] round_val;
    logic                              round_sat;

    // Stage 1: full-precision product plus round-boundary markers for this tap
    always_ff @(posedge clk) begin
        if (rst) begin
            prod_r  <= '0;
            first_r <= 1'b0;
            last_r  <= 1'b0;
        end else begin
            prod_r  <= PROD_BITS'(delay_filter_in) * PROD_BITS'(coeff);
            first_r <= phase_min;
            last_r  <= current_count == COUNTER_BITS'(NUMBER_OF_TAPS - 1);
        end
    end

    // Stage 2 combinational: restart or extend the running sum; emit only for rounds that began at a first tap
    always_comb begin
        sum  = first_r ? ACC_BITS'(prod_r) : acc + ACC_BITS'(prod_r);
        emit = last_r && (armed || first_r);
    end

    fir_round_sat #(
        .IN_BITS (ACC_BITS),
        .OUT_BITS(FILTER_OUT_BITS),
        .SHIFT   (OUT_SHIFT)
    ) u_round_sat (
        .din (sum),
        .dout(round_val),
        .sat (round_sat)
    );

    // Stage 2 registers: accumulator, round arming, output sample and sticky saturation (set beats clear)
    always_ff @(posedge clk) begin
        if (rst) begin
            acc              <= '0;
            armed            <= 1'b0;
            filter_out       <= '0;
            filter_out_valid <= 1'b0;
            sat_flag         <= 1'b0;
        end else begin
            acc              <= sum;
            armed            <= emit ? 1'b0 : first_r ? 1'b1 : armed;
            filter_out       <= emit ? round_val : filter_out;
            filter_out_valid <= emit;
            sat_flag         <= (emit && round_sat) || (sat_flag && !clear_sat);
        end
    end

endmodule

// File: tb/tb_fir_mac_accumulator.sv
// tb_fir_mac_accumulator: directed scoreboard bench over 64-tap, 4-tap and 1-tap accumulators
module tb_fir_mac_accumulator;

    typedef struct {
        longint             cyc;
        logic signed [15:0] val;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic               pm  [3];
    logic        [5:0]  cnt [3];
    logic signed [15:0] din [3];
    logic signed [15:0] cf  [3];
    logic               clr [3];
    logic signed [15:0] fo  [3];
    logic               fv  [3];
    logic               sf  [3];

    exp_t               q [3][$];
    longint             cyc = 0;
    int                 checks = 0;
    int                 errors = 0;
    int                 shifts [3] = '{15, 2, 1};
    logic signed [15:0] da [64];
    logic signed [15:0] ca [64];

    fir_mac_accumulator u_d0 (
        .clk(clk), .rst(rst), .phase_min(pm[0]), .current_count(cnt[0]),
        .delay_filter_in(din[0]), .coeff(cf[0]), .clear_sat(clr[0]),
        .filter_out(fo[0]), .filter_out_valid(fv[0]), .sat_flag(sf[0])
    );

    fir_mac_accumulator #(.NUMBER_OF_TAPS(4), .OUT_SHIFT(2)) u_d1 (
        .clk(clk), .rst(rst), .phase_min(pm[1]), .current_count(cnt[1][1:0]),
        .delay_filter_in(din[1]), .coeff(cf[1]), .clear_sat(clr[1]),
        .filter_out(fo[1]), .filter_out_valid(fv[1]), .sat_flag(sf[1])
    );

    fir_mac_accumulator #(.NUMBER_OF_TAPS(1), .OUT_SHIFT(1)) u_d2 (
        .clk(clk), .rst(rst), .phase_min(pm[2]), .current_count(cnt[2][0:0]),
        .delay_filter_in(din[2]), .coeff(cf[2]), .clear_sat(clr[2]),
        .filter_out(fo[2]), .filter_out_valid(fv[2]), .sat_flag(sf[2])
    );

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    function automatic logic signed [15:0] model(input longint s, input int sh);
        longint r;
        r = (s + (longint'(1) << (sh - 1))) >>> sh;
        return r > 32767 ? 16'sh7fff : r < -32768 ? 16'sh8000 : 16'(r);
    endfunction

    task automatic monitor();
        exp_t e;
        logic want;
        for (int d = 0; d < 3; d++) begin
            want = q[d].size() > 0 && q[d][0].cyc == cyc;
            chk($sformatf("valid_d%0d_cyc%0d", d, cyc), fv[d], want);
            if (want) begin
                e = q[d].pop_front();
                chk($sformatf("value_d%0d_cyc%0d", d, cyc), fo[d], e.val);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        monitor();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic round(input int d, input int n, input int lo, input int hi, input bit expect_out);
        longint s = 0;
        exp_t e;
        for (int k = lo; k <= hi; k++) begin
            pm[d]  = k == 0;
            cnt[d] = 6'(k);
            din[d] = da[k];
            cf[d]  = ca[k];
            s += longint'(da[k]) * longint'(ca[k]);
            if (expect_out && k == n - 1) begin
                e.cyc = cyc + 2;
                e.val = model(s, shifts[d]);
                q[d].push_back(e);
            end
            step();
        end
        pm[d]  = 1'b0;
        cnt[d] = '0;
    endtask

    task automatic fill(input logic signed [15:0] x, input logic signed [15:0] c);
        for (int k = 0; k < 64; k++) begin
            da[k] = x;
            ca[k] = c;
        end
    endtask

    task automatic fill_rand(input int mag);
        for (int k = 0; k < 64; k++) begin
            da[k] = 16'(int'($urandom_range(0, 2 * mag)) - mag);
            ca[k] = 16'(int'($urandom_range(0, 2 * mag)) - mag);
        end
    endtask

    initial begin
        rst = 1'b1;
        for (int d = 0; d < 3; d++) begin
            pm[d] = 1'b0; cnt[d] = '0; din[d] = '0; cf[d] = '0; clr[d] = 1'b0;
        end
        idle(2);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("reset_out_d%0d", d), fo[d], 0);
            chk($sformatf("reset_valid_d%0d", d), fv[d], 0);
            chk($sformatf("reset_sat_d%0d", d), sf[d], 0);
        end
        rst = 1'b0;
        idle(1);

        da[0:3] = '{16'sd2, 16'sd2, 16'sd2, 16'sd2};
        ca[0:3] = '{16'sd1, 16'sd2, 16'sd3, 16'sd4};
        round(1, 4, 0, 3, 1);
        idle(3);
        chk("impulse_value_held", fo[1], 5);

        da[0:3] = '{16'sd1, 16'sd1, 16'sd1, 16'sd1};
        ca[0:3] = '{16'sd1, 16'sd2, 16'sd3, 16'sd0};
        round(1, 4, 0, 3, 1);
        ca[0:3] = '{-16'sd1, -16'sd2, -16'sd3, 16'sd0};
        round(1, 4, 0, 3, 1);
        idle(3);
        chk("round_neg_held", fo[1], -1);

        for (int i = 0; i < 5; i++) begin
            fill_rand(200);
            round(2, 1, 0, 0, 1);
        end
        idle(3);
        chk("n1_no_sat", sf[2], 0);
        da[0] = 16'sh7fff;
        ca[0] = 16'sh7fff;
        round(2, 1, 0, 0, 1);
        idle(3);
        chk("n1_sat_set", sf[2], 1);

        fill(16'sh7fff, 16'sh7fff);
        round(0, 64, 0, 63, 1);
        idle(3);
        chk("sat_pos_flag", sf[0], 1);
        idle(5);
        chk("sat_pos_held", sf[0], 1);
        clr[0] = 1'b1;
        step();
        clr[0] = 1'b0;
        chk("sat_cleared", sf[0], 0);
        round(0, 64, 0, 63, 1);
        clr[0] = 1'b1;
        step();
        clr[0] = 1'b0;
        chk("sat_set_beats_clear", sf[0], 1);
        idle(2);
        fill(16'sh8000, 16'sh7fff);
        round(0, 64, 0, 63, 1);
        idle(3);
        chk("sat_neg_value", fo[0], -32768);

        fill_rand(2000);
        round(0, 64, 0, 29, 0);
        cnt[0] = 6'd30;
        din[0] = da[30];
        cf[0]  = ca[30];
        rst    = 1'b1;
        step();
        chk("midrst_out", fo[0], 0);
        chk("midrst_valid", fv[0], 0);
        chk("midrst_sat", sf[0], 0);
        rst = 1'b0;
        round(0, 64, 31, 63, 0);
        round(0, 64, 0, 63, 1);
        idle(3);

        fill_rand(2000);
        round(0, 64, 0, 9, 0);
        fill_rand(2000);
        round(0, 64, 0, 63, 1);
        idle(3);

        for (int r = 0; r < 3; r++) begin
            fill_rand(2000);
            round(0, 64, 0, 63, 1);
        end
        idle(4);

        for (int d = 0; d < 3; d++) chk($sformatf("drain_d%0d", d), q[d].size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
